// File: rtl/class_similarity_search_if.sv
// Bus bundle for the class similarity search stage: query frame stream in,
// class ROM address out / data in, and the argmin result handshake out.
interface class_similarity_search_if #(
   parameter int FRAME_WIDTH = 64,
   parameter int CLASS_ID_W  = 3,
   parameter int FRAME_IDX_W = 2,
   parameter int DIST_W      = 8
);
   logic [FRAME_WIDTH-1:0] q_frame;
   logic                   q_valid;
   logic                   q_ready;
   logic [CLASS_ID_W-1:0]  cv_frame_id;
   logic [FRAME_IDX_W-1:0] cv_frame_index;
   logic [FRAME_WIDTH-1:0] class_vec_in;
   logic                   result_valid;
   logic                   result_ready;
   logic [CLASS_ID_W-1:0]  result_class;
   logic [DIST_W-1:0]      result_dist;

   // Query source, class ROM and result consumer side.
   modport master (
      output q_frame, q_valid, class_vec_in, result_ready,
      input  q_ready, cv_frame_id, cv_frame_index, result_valid, result_class, result_dist
   );

   // Search engine side.
   modport slave (
      input  q_frame, q_valid, class_vec_in, result_ready,
      output q_ready, cv_frame_id, cv_frame_index, result_valid, result_class, result_dist
   );
endinterface

// File: rtl/class_similarity_search.sv
// Associative search: buffers a query hypervector, walks every class frame of
// the class ROM, accumulates per-class Hamming distance in a two-stage
// pipeline and reports the class with the smallest distance.
module class_similarity_search #(
   parameter int NUM_CLASSES = 8,
   parameter int NUM_FRAMES  = 3,
   parameter int FRAME_WIDTH = 64,
   parameter int CLASS_ID_W  = 3,
   parameter int FRAME_IDX_W = 2,
   parameter int DIST_W      = 8
) (
   input logic                      clk,
   input logic                      rst,
   class_similarity_search_if.slave bus
);

   localparam int PART_W = $clog2(FRAME_WIDTH + 1);
   localparam logic [FRAME_IDX_W-1:0] LAST_FRM = FRAME_IDX_W'(NUM_FRAMES - 1);
   localparam logic [CLASS_ID_W-1:0]  LAST_CLS = CLASS_ID_W'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SEARCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [FRAME_IDX_W-1:0] load_cnt;
   logic [FRAME_IDX_W-1:0] frm;
   logic [CLASS_ID_W-1:0]  cls;
   logic [FRAME_WIDTH-1:0] qbuf [NUM_FRAMES];
   logic                   accept;
   logic                   issue;

   // Stage 1: per-frame partial distance with its class tag.
   logic                   s1_valid;
   logic                   s1_last;
   logic [CLASS_ID_W-1:0]  s1_tag;
   logic [PART_W-1:0]      s1_part;

   // Stage 2: per-class accumulator and running minimum.
   logic [DIST_W-1:0]      acc;
   logic [DIST_W-1:0]      s2_total;
   logic [DIST_W-1:0]      best_dist;
   logic [CLASS_ID_W-1:0]  best_class;

   function automatic logic [PART_W-1:0] popcount(input logic [FRAME_WIDTH-1:0] v);
      logic [PART_W-1:0] n;
      n = '0;
      for (int i = 0; i < FRAME_WIDTH; i++) n = n + PART_W'(v[i]);
      return n;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_LOAD;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake/address outputs.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' with every output defaulted
      // first, so no path leaves a signal unassigned and no latch is inferred.
      state_nxt          = state;
      bus.q_ready        = 1'b0;
      bus.cv_frame_id    = '0;
      bus.cv_frame_index = '0;
      bus.result_valid   = 1'b0;
      accept             = 1'b0;
      issue              = 1'b0;
      case (state)
         S_LOAD: begin
            bus.q_ready = !rst;
            accept      = bus.q_valid && !rst;
            if (accept && load_cnt == LAST_FRM) state_nxt = S_SEARCH;
         end
         S_SEARCH: begin
            issue              = 1'b1;
            bus.cv_frame_id    = cls;
            bus.cv_frame_index = frm;
            if (cls == LAST_CLS && frm == LAST_FRM) state_nxt = S_DRAIN;
         end
         S_DRAIN: state_nxt = S_DONE;
         S_DONE: begin
            bus.result_valid = 1'b1;
            if (bus.result_ready) state_nxt = S_LOAD;
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   // Query buffer write; only the accept strobe guards it.
   always_ff @(posedge clk) begin
      // NOTE: the query buffer is storage, not control state, so it has no
      // reset; a stale query can never be searched because load_cnt restarts.
      if (accept) qbuf[load_cnt] <= bus.q_frame;
   end

   // Load counter plus class/frame walk counters.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         load_cnt <= '0;
         frm      <= '0;
         cls      <= '0;
      end else begin
         if (accept) load_cnt <= (load_cnt == LAST_FRM) ? '0 : load_cnt + 1'b1;
         if (issue) begin
            if (frm == LAST_FRM) begin
               frm <= '0;
               cls <= (cls == LAST_CLS) ? '0 : cls + 1'b1;
            end else begin
               frm <= frm + 1'b1;
            end
         end
      end
   end

   // Stage 1: XOR the ROM frame with the matching query frame and count ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_tag   <= '0;
         s1_part  <= '0;
      end else begin
         s1_valid <= issue;
         s1_last  <= (frm == LAST_FRM);
         s1_tag   <= cls;
         s1_part  <= popcount(bus.class_vec_in ^ qbuf[frm]);
      end
   end

   // Class total including the partial arriving this cycle.
   always_comb begin
      s2_total = acc + DIST_W'(s1_part);
   end

   // Stage 2: accumulate per class and keep the strict minimum (ties keep the lower index).
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         best_dist  <= '0;
         best_class <= '0;
      end else if (s1_valid) begin
         if (s1_last) begin
            acc <= '0;
            if (s1_tag == '0 || s2_total < best_dist) begin
               best_dist  <= s2_total;
               best_class <= s1_tag;
            end
         end else begin
            acc <= s2_total;
         end
      end
   end

   assign bus.result_class = best_class;
   assign bus.result_dist  = best_dist;

endmodule
